// File: rtl/spart_driver.sv
// SPART echo driver: loads the baud divisor for br_cfg, then echoes each received byte back out.
// Optional macro SPART_DRV_RECFG_EN: reload the divisor when br_cfg settles on a new value.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_CFG_LO   | write divisor low byte to ioaddr 10 (held idle until first edge after reset)
// S_CFG_HI   | write divisor high byte to ioaddr 11
// S_WAIT_RDA | idle, waiting for received data
// S_RD       | read strobe on ioaddr 00, byte captured into hold register
// S_WAIT_TBR | idle with a held byte, waiting for transmit buffer ready
// S_WR       | write held byte to ioaddr 00, bump echo count
module spart_driver #(
    parameter int SETTLE_CYC = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_br_cfg,
    input  logic       i_rda,
    input  logic       i_tbr,
    input  logic [7:0] i_databus_in,
    output logic       o_iocs,
    output logic       o_iorw,
    output logic [1:0] o_ioaddr,
    output logic [7:0] o_databus_out,
    output logic       o_cfg_done,
    output logic [7:0] o_echo_cnt
);

    typedef enum logic [2:0] {
        S_CFG_LO,
        S_CFG_HI,
        S_WAIT_RDA,
        S_RD,
        S_WAIT_TBR,
        S_WR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_started;
    logic        r_cfg_done;
    logic [1:0]  r_cfg;
    logic [7:0]  r_hold;
    logic [7:0]  r_echo_cnt;
    logic [15:0] w_div;
    logic        w_pend;
    logic        w_resume;
    logic        w_settle_hit;
    logic        w_enter_cfg;

    always_comb begin
        w_div = 16'h0516;
        case (r_cfg)
            2'b00:   w_div = 16'h0516;
            2'b01:   w_div = 16'h028B;
            2'b10:   w_div = 16'h0145;
            default: w_div = 16'h00A2;
        endcase
    end

    assign w_enter_cfg = w_pend && ((r_state == S_WAIT_RDA) || (r_state == S_WAIT_TBR));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CFG_LO:   if (r_started) w_next = S_CFG_HI;
            S_CFG_HI:   w_next = w_resume ? S_WAIT_TBR : S_WAIT_RDA;
            S_WAIT_RDA: begin
                if (w_pend)     w_next = S_CFG_LO;
                else if (i_rda) w_next = S_RD;
            end
            S_RD:       w_next = S_WAIT_TBR;
            S_WAIT_TBR: begin
                if (w_pend)     w_next = S_CFG_LO;
                else if (i_tbr) w_next = S_WR;
            end
            S_WR:       w_next = S_WAIT_RDA;
            default:    w_next = S_CFG_LO;
        endcase
    end

    // r_started keeps the bus quiet in the cycle between reset release and the first edge.
    always_comb begin
        o_iocs        = 1'b0;
        o_iorw        = 1'b1;
        o_ioaddr      = 2'b00;
        o_databus_out = 8'h00;
        if (r_started) begin
            case (r_state)
                S_CFG_LO: begin
                    o_iocs        = 1'b1;
                    o_iorw        = 1'b0;
                    o_ioaddr      = 2'b10;
                    o_databus_out = w_div[7:0];
                end
                S_CFG_HI: begin
                    o_iocs        = 1'b1;
                    o_iorw        = 1'b0;
                    o_ioaddr      = 2'b11;
                    o_databus_out = w_div[15:8];
                end
                S_RD: begin
                    o_iocs = 1'b1;
                end
                S_WR: begin
                    o_iocs        = 1'b1;
                    o_iorw        = 1'b0;
                    o_databus_out = r_hold;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_CFG_LO;
            r_started  <= 1'b0;
            r_cfg      <= 2'b00;
            r_cfg_done <= 1'b0;
            r_hold     <= 8'h00;
            r_echo_cnt <= 8'h00;
        end else begin
            r_state   <= w_next;
            r_started <= 1'b1;
            // Divisor select latched once per configuration pass so LO/HI always match.
            if (!r_started || w_enter_cfg)
                r_cfg <= i_br_cfg;
            if (w_settle_hit)
                r_cfg_done <= 1'b0;
            else if (r_state == S_CFG_HI)
                r_cfg_done <= 1'b1;
            if (r_state == S_RD)
                r_hold <= i_databus_in;
            if (r_state == S_WR)
                r_echo_cnt <= r_echo_cnt + 8'h01;
        end
    end

`ifdef SPART_DRV_RECFG_EN
    localparam int CW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYC);

    logic [CW-1:0] r_settle;
    logic [CW-1:0] w_settle_nxt;
    logic [1:0]    r_prev_cfg;
    logic          r_pend;
    logic          r_resume;

    // Count consecutive cycles of one stable value that differs from the loaded one.
    always_comb begin
        w_settle_nxt = '0;
        if (r_cfg_done && (i_br_cfg != r_cfg)) begin
            if ((r_settle != '0) && (i_br_cfg == r_prev_cfg))
                w_settle_nxt = (r_settle == SETTLE_MAX) ? r_settle : r_settle + 1'b1;
            else
                w_settle_nxt = CW'(1);
        end
    end

    assign w_settle_hit = (w_settle_nxt == SETTLE_MAX) && (r_settle != SETTLE_MAX);
    assign w_pend       = r_pend;
    assign w_resume     = r_resume;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_settle   <= '0;
            r_prev_cfg <= 2'b00;
            r_pend     <= 1'b0;
            r_resume   <= 1'b0;
        end else begin
            r_settle   <= w_settle_nxt;
            r_prev_cfg <= i_br_cfg;
            if (w_settle_hit)
                r_pend <= 1'b1;
            else if (w_enter_cfg)
                r_pend <= 1'b0;
            // Remember a pending transmit so it resumes after the divisor reload.
            if (w_enter_cfg)
                r_resume <= (r_state == S_WAIT_TBR);
            else if (r_state == S_CFG_HI)
                r_resume <= 1'b0;
        end
    end
`else
    assign w_settle_hit = 1'b0;
    assign w_pend       = 1'b0;
    assign w_resume     = 1'b0;
`endif

    assign o_cfg_done = r_cfg_done;
    assign o_echo_cnt = r_echo_cnt;

endmodule

// File: doc/spart_driver.md
SPART_DRIVER -- requirements
Module: spart_driver

Interface
REQ-001 Parameter SETTLE_CYC, default 4: number of consecutive cycles br_cfg must hold a new value before reconfiguration starts.
REQ-002 clk  input  1  system clock, 100 MHz; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-low.
REQ-004 br_cfg  input  2  baud select from dip switches: 00=4800, 01=9600, 10=19200, 11=38400.
REQ-005 rda  input  1  SPART receive data available.
REQ-006 tbr  input  1  SPART transmit buffer ready.
REQ-007 databus_in  input  8  read data from SPART, valid in the same cycle as a read strobe.
REQ-008 iocs  output  1  SPART chip select, one-cycle strobe per access.
REQ-009 iorw  output  1  1=read, 0=write; meaningful only while iocs=1.
REQ-010 ioaddr  output  2  00=data (tx/rx), 01=status (unused), 10=divisor low, 11=divisor high.
REQ-011 databus_out  output  8  write data, valid while iocs=1 and iorw=0.
REQ-012 cfg_done  output  1  high once the divisor for the current br_cfg is loaded.
REQ-013 echo_cnt  output  8  count of bytes echoed since reset.

Function
REQ-014 FSM states: CFG_LO, CFG_HI, WAIT_RDA, RD, WAIT_TBR, WR; exactly one SPART access (iocs=1) per cycle at most.
REQ-015 Divisor table (100 MHz, 16x oversample): 00->16'h0516, 01->16'h028B, 10->16'h0145, 11->16'h00A2.
REQ-016 CFG_LO: iocs=1, iorw=0, ioaddr=10, databus_out=divisor[7:0]; next CFG_HI.
REQ-017 CFG_HI: iocs=1, iorw=0, ioaddr=11, databus_out=divisor[15:8]; cfg_done set next cycle; next WAIT_RDA.
REQ-018 Divisor is sampled from br_cfg once on entry to CFG_LO and held for CFG_HI; a br_cfg change between the two writes does not split the divisor.
REQ-019 WAIT_RDA: iocs=0; on rda=1 go to RD.
REQ-020 RD: iocs=1, iorw=1, ioaddr=00; databus_in captured into 8-bit hold register at this edge; next WAIT_TBR.
REQ-021 WAIT_TBR: iocs=0; on tbr=1 go to WR; rda activity ignored (single-byte buffer, no second read).
REQ-022 WR: iocs=1, iorw=0, ioaddr=00, databus_out=hold register; echo_cnt increments, wraps 8'hFF->8'h00; next WAIT_RDA.
REQ-023 Minimum echo latency: rda high in cycle N -> read strobe N+1 -> write strobe N+3 if tbr already high.
REQ-024 While iocs=0: iorw=1, ioaddr=00, databus_out=8'h00.

Reset
REQ-025 rst low asynchronously forces: state=CFG_LO, iocs=0, iorw=1, ioaddr=00, databus_out=00, cfg_done=0, echo_cnt=00, hold register=00, settle counter=0.
REQ-026 First access after rst deasserts is the CFG_LO write on the first rising edge; reset mid-access aborts it with no partial strobe.

Configuration
REQ-027 Macro SPART_DRV_RECFG_EN.
REQ-028 Defined: a settle counter tracks br_cfg against the loaded value; after SETTLE_CYC consecutive cycles of a different stable value, cfg_done clears and the FSM enters CFG_LO at the next WAIT_RDA or WAIT_TBR state; a held byte in WAIT_TBR is preserved and transmitted after reconfiguration; any br_cfg glitch shorter than SETTLE_CYC restarts the count.
REQ-029 Undefined: br_cfg is sampled only after reset; later changes are ignored and cfg_done stays high until the next reset.

Verification
REQ-030 Reset release with br_cfg=01 -> write 8'h8B to ioaddr 10, next cycle 8'h02 to ioaddr 11, cfg_done=1 afterwards.
REQ-031 rda pulse with databus_in=8'h40, tbr=1 -> read strobe next cycle, write of 8'h40 to ioaddr 00 two cycles later, echo_cnt=1.
REQ-032 tbr=0 for 50 cycles after read, extra rda pulses -> no further reads; single write once tbr=1.
REQ-033 256 echoes -> echo_cnt wraps to 8'h00.
REQ-034 With SPART_DRV_RECFG_EN, br_cfg 00->11 held 4 cycles -> cfg_done falls, writes 8'hA2 then 8'h00; 3-cycle glitch -> no reconfiguration.
REQ-035 rst asserted during WAIT_TBR -> outputs at reset values immediately, held byte discarded, CFG_LO write after release.
